// File: rtl/hdng_err_gen.sv
// hdng_err_gen -- heading integrator and saturated heading-error generator.
//
// Calibrates a yaw-rate offset by averaging 2^CAL_LOG2 samples. After
// calibration, integrates offset-corrected yaw rate into a 24-bit wrapping
// accumulator and produces a saturated signed heading error against a
// desired heading.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   strt_cal   in   one-cycle pulse: (re)start offset calibration
//   vld        in   one-cycle strobe: yaw_rt holds a new sample
//   yaw_rt     in   [15:0] signed raw yaw rate
//   dsrd_hdng  in   [11:0] desired heading (circular, one turn = 4096)
//   heading    out  [11:0] integrated heading (accumulator bits [23:12])
//   err_sat    out  [9:0]  signed heading error clamped to [-512,511]
//   hdng_vld   out  one-cycle pulse: err_sat is fresh
//   cal_done   out  level: calibration has completed
module hdng_err_gen #(
  parameter int unsigned CAL_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cal,
  input  logic        vld,
  input  logic [15:0] yaw_rt,
  input  logic [11:0] dsrd_hdng,
  output logic [11:0] heading,
  output logic [9:0]  err_sat,
  output logic        hdng_vld,
  output logic        cal_done
);

  typedef enum logic [1:0] {IDLE, CAL, RUN} state_e;

  state_e              state_q;
  logic [CAL_LOG2-1:0] cnt_q;
  logic [19:0]         sum_q;
  logic [15:0]         offset_q;
  logic [23:0]         acc_q;
  logic [9:0]          err_q;
  logic                hv_q;
  logic                done_q;
  logic                pend_q;

  logic [19:0]         sum_d;
  logic signed [19:0]  sum_shr;
  logic [16:0]         diff;
  logic [23:0]         acc_d;
  logic [11:0]         err12;
  logic [9:0]          err_d;

  always_comb begin
    sum_d   = sum_q + {{4{yaw_rt[15]}}, yaw_rt};
    sum_shr = $signed(sum_d) >>> CAL_LOG2;
    diff    = {yaw_rt[15], yaw_rt} - {offset_q[15], offset_q};
    acc_d   = acc_q + {{7{diff[16]}}, diff};
    // Modulo-4096 subtraction read as signed gives the shortest-path error.
    err12   = acc_q[23:12] - dsrd_hdng;
    if ($signed(err12) > $signed(12'sd511)) begin
      err_d = 10'h1FF;
    end else if ($signed(err12) < $signed(-12'sd512)) begin
      err_d = 10'h200;
    end else begin
      err_d = err12[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sum_q    <= '0;
      offset_q <= '0;
      acc_q    <= '0;
      err_q    <= '0;
      hv_q     <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      hv_q   <= 1'b0;
      pend_q <= 1'b0;
      // Error is registered one edge after the accumulator update; a
      // coincident strt_cal drops it so no pulse escapes into CAL.
      if (pend_q && !strt_cal) begin
        err_q <= err_d;
        hv_q  <= 1'b1;
      end
      if (strt_cal) begin
        state_q <= CAL;
        cnt_q   <= '0;
        sum_q   <= '0;
        acc_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          CAL: begin
            if (vld) begin
              sum_q <= sum_d;
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == '1) begin
                offset_q <= sum_shr[15:0];
                done_q   <= 1'b1;
                state_q  <= RUN;
              end
            end
          end
          RUN: begin
            if (vld) begin
              acc_q  <= acc_d;
              pend_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign heading  = acc_q[23:12];
  assign err_sat  = err_q;
  assign hdng_vld = hv_q;
  assign cal_done = done_q;

endmodule

// File: tb/tb_hdng_err_gen.sv
module tb_hdng_err_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strt_cal;
  logic        vld;
  logic [15:0] yaw_rt;
  logic [11:0] dsrd_hdng;
  logic [11:0] heading;
  logic [9:0]  err_sat;
  logic        hdng_vld;
  logic        cal_done;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] sb[$];

  hdng_err_gen #(.CAL_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld),
    .yaw_rt(yaw_rt), .dsrd_hdng(dsrd_hdng), .heading(heading),
    .err_sat(err_sat), .hdng_vld(hdng_vld), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every hdng_vld pulse must match the oldest expected error.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && hdng_vld === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_hdng_vld", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check("err_sat", err_sat, e);
      end
    end
  end

  task automatic cal_loop(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 16; i++) begin
      vld = 1'b1;
      yaw_rt = (i < 8) ? a : b;
      tick();
      vld = 1'b0;
      if (i == 14) check("cal_done_before_last", cal_done, 0);
      if (i == 15) check("cal_done_at_last", cal_done, 1);
      tick();
    end
  endtask

  task automatic cal16(input logic [15:0] a, input logic [15:0] b);
    strt_cal = 1'b1;
    tick();
    strt_cal = 1'b0;
    check("cal_done_on_cal_entry", cal_done, 0);
    cal_loop(a, b);
  endtask

  task automatic run_sample(input logic [15:0] yaw, input logic [11:0] exp_h,
                            input logic [9:0] exp_e);
    yaw_rt = yaw;
    vld = 1'b1;
    sb.push_back(exp_e);
    tick();
    vld = 1'b0;
    check("heading", heading, exp_h);
    check("hdng_vld_early", hdng_vld, 0);
    tick();
    check("hdng_vld_pulse", hdng_vld, 1);
    tick();
    check("hdng_vld_width", hdng_vld, 0);
  endtask

  initial begin
    rst_n = 1'b0; strt_cal = 1'b0; vld = 1'b0; yaw_rt = '0; dsrd_hdng = '0;
    tick(); tick();
    rst_n = 1'b1;

    // Idle with vld toggling: nothing moves.
    for (int i = 0; i < 10; i++) begin
      vld = i[0];
      yaw_rt = 16'h1234;
      tick();
    end
    vld = 1'b0;
    check("idle_heading", heading, 0);
    check("idle_err", err_sat, 0);
    check("idle_cal_done", cal_done, 0);

    // Calibrate at 0x40, then integrate +1 heading LSB per sample.
    cal16(16'h0040, 16'h0040);
    dsrd_hdng = 12'h000;
    for (int i = 1; i <= 4; i++) run_sample(16'h1040, 12'(i), 10'(i));

    // Wrap and clamps with zero net rate.
    dsrd_hdng = 12'hFFE; run_sample(16'h0040, 12'h004, 10'h006);
    dsrd_hdng = 12'h300; run_sample(16'h0040, 12'h004, 10'h200);
    dsrd_hdng = 12'hD00; run_sample(16'h0040, 12'h004, 10'h1FF);

    // dsrd_hdng change without vld must not disturb err_sat.
    dsrd_hdng = 12'h000;
    tick(); tick();
    check("err_hold", err_sat, 10'h1FF);

    // Sample then strt_cal next cycle: pending pulse is dropped.
    vld = 1'b1; yaw_rt = 16'h1040;
    tick();
    vld = 1'b0;
    check("pre_cal_heading", heading, 12'h005);
    strt_cal = 1'b1;
    tick();
    strt_cal = 1'b0;
    check("suppress_hdng_vld", hdng_vld, 0);
    check("suppress_heading", heading, 0);
    check("suppress_cal_done", cal_done, 0);
    tick();
    check("suppress_hdng_vld2", hdng_vld, 0);

    // Partial CAL with a large value, then restart: count and sum cleared.
    for (int i = 0; i < 5; i++) begin
      vld = 1'b1; yaw_rt = 16'h7000; tick(); vld = 1'b0; tick();
    end
    cal16(16'h0041, 16'h0040);          // sum 0x408 -> offset 0x40 (floor)
    run_sample(16'h1040, 12'h001, 10'h001);

    // strt_cal coincident with vld in RUN: sample discarded.
    strt_cal = 1'b1; vld = 1'b1; yaw_rt = 16'h1040;
    tick();
    strt_cal = 1'b0; vld = 1'b0;
    check("coinc_heading", heading, 0);
    check("coinc_cal_done", cal_done, 0);
    check("coinc_hdng_vld", hdng_vld, 0);
    tick();
    check("coinc_hdng_vld2", hdng_vld, 0);
    cal_loop(16'h0040, 16'h0040);
    run_sample(16'h1040, 12'h001, 10'h001);

    // Asynchronous reset in RUN.
    #2 rst_n = 1'b0;
    #1;
    check("rst_run_heading", heading, 0);
    check("rst_run_err", err_sat, 0);
    check("rst_run_cal_done", cal_done, 0);
    tick();
    rst_n = 1'b1;

    // Reset after 8 CAL samples.
    strt_cal = 1'b1; tick(); strt_cal = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vld = 1'b1; yaw_rt = 16'h0040; tick(); vld = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_cal_cal_done", cal_done, 0);
    check("rst_cal_heading", heading, 0);
    check("rst_cal_hdng_vld", hdng_vld, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vld = 1'b1; yaw_rt = 16'h1040; tick(); vld = 1'b0; tick();
    end
    check("post_rst_cal_done", cal_done, 0);
    check("post_rst_heading", heading, 0);

    // Negative offset with floor rounding: sum -1032 -> offset 0xFFBF.
    cal16(16'hFFBF, 16'hFFC0);
    dsrd_hdng = 12'hFFF;
    run_sample(16'h0FBF, 12'h001, 10'h002);

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
